// File: rtl/systolic_drain.sv
// Result drain for the systolic array: removes the weight-stationary column skew
// from the bottom-row sum bus and queues aligned result rows behind a valid/ready stream.
module systolic_drain #(
  parameter int unsigned SUM_WIDTH      = 16,
  parameter int unsigned SYSTOLIC_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0] sum_in,
  input  logic                                mode,
  input  logic                                start,
  input  logic [CNT_WIDTH-1:0]                row_count,
  input  logic [CNT_WIDTH-1:0]                first_lat,
  output logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0] out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy,
  output logic                                done,
  output logic                                overflow
);

  localparam int unsigned W  = SYSTOLIC_WIDTH;
  localparam int unsigned RW = W * SUM_WIDTH;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OW = AW + 1;
  localparam int unsigned DW = CNT_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE} state_e;

  state_e               state_q, state_d;
  logic [DW-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic                 mode_q, mode_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 ovf_q, ovf_d;
  logic                 ovf_clr, wr_en;
  logic [DW-1:0]        lat_eff, delay;

  logic [RW-1:0]        direct_row, skew_row, wr_row;
  logic [RW-1:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [OW-1:0]        count_q, count_d;
  logic                 valid_q;
  logic                 full, pop, push, drop;

  // Per-column deskew: column k is delayed by W-1-k cycles so all columns of a row line up.
  for (genvar k = 0; k < W; k++) begin : g_col
    localparam int unsigned DEP = W - 1 - k;
    logic [SUM_WIDTH-1:0] col;
    assign col = sum_in[(W-1-k)*SUM_WIDTH +: SUM_WIDTH];
    assign direct_row[k*SUM_WIDTH +: SUM_WIDTH] = col;
    if (DEP == 0) begin : g_nodly
      assign skew_row[k*SUM_WIDTH +: SUM_WIDTH] = col;
    end else begin : g_dly
      logic [DEP*SUM_WIDTH-1:0] chain_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain_q <= '0;
        else        chain_q <= (DEP*SUM_WIDTH)'({chain_q, col});
      end
      assign skew_row[k*SUM_WIDTH +: SUM_WIDTH] = chain_q[DEP*SUM_WIDTH-1 -: SUM_WIDTH];
    end
  end

  assign wr_row  = mode_q ? direct_row : skew_row;
  assign lat_eff = (first_lat == '0) ? DW'(1) : DW'(first_lat);
  assign delay   = lat_eff + (mode ? DW'(0) : DW'(W - 1));

  // Control FSM: wait out the pipeline latency, then write one row per cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    ovf_clr = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          ovf_clr = 1'b1;
          if (row_count == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d = row_count;
            if (delay == DW'(1)) begin
              state_d = S_CAPTURE;
            end else begin
              cnt_d   = delay - DW'(2);
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_CAPTURE;
        else             cnt_d   = cnt_q - DW'(1);
      end
      S_CAPTURE: begin
        wr_en = 1'b1;
        if (rem_q == CNT_WIDTH'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          rem_d = rem_q - CNT_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) || done_d;
  end

  // A full FIFO still accepts a row when the head is popped on the same edge.
  assign full    = (count_q == OW'(FIFO_DEPTH));
  assign pop     = valid_q && out_ready;
  assign push    = wr_en && (!full || pop);
  assign drop    = wr_en && full && !pop;
  assign count_d = count_q + OW'(push) - OW'(pop);
  assign ovf_d   = ovf_clr ? 1'b0 : (ovf_q || drop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result FIFO storage and pointers; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[AW'(i)] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= wr_row;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  assign out_data  = mem_q[rd_q];
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;

endmodule
